// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: FSM state
// encoding, opcode/funct/REGIMM-rt constants and datapath mux encodings.
package mips_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned FN_W  = 6;
  localparam int unsigned RT_W  = 5;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_MULDIV_WAIT,
    ST_HALTED
  } state_e;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_RTYPE  = 6'h00;
  localparam logic [OP_W-1:0] OP_REGIMM = 6'h01;
  localparam logic [OP_W-1:0] OP_J      = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL    = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE    = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ   = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ   = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI   = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU  = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI   = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU  = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI   = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI    = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI   = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI    = 6'h0F;
  localparam logic [OP_W-1:0] OP_LB     = 6'h20;
  localparam logic [OP_W-1:0] OP_LH     = 6'h21;
  localparam logic [OP_W-1:0] OP_LWL    = 6'h22;
  localparam logic [OP_W-1:0] OP_LW     = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU    = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU    = 6'h25;
  localparam logic [OP_W-1:0] OP_LWR    = 6'h26;
  localparam logic [OP_W-1:0] OP_SB     = 6'h28;
  localparam logic [OP_W-1:0] OP_SH     = 6'h29;
  localparam logic [OP_W-1:0] OP_SW     = 6'h2B;

  // R-type function codes
  localparam logic [FN_W-1:0] FN_SLL   = 6'h00;
  localparam logic [FN_W-1:0] FN_SRL   = 6'h02;
  localparam logic [FN_W-1:0] FN_SRA   = 6'h03;
  localparam logic [FN_W-1:0] FN_SLLV  = 6'h04;
  localparam logic [FN_W-1:0] FN_SRLV  = 6'h06;
  localparam logic [FN_W-1:0] FN_SRAV  = 6'h07;
  localparam logic [FN_W-1:0] FN_JR    = 6'h08;
  localparam logic [FN_W-1:0] FN_JALR  = 6'h09;
  localparam logic [FN_W-1:0] FN_MFHI  = 6'h10;
  localparam logic [FN_W-1:0] FN_MTHI  = 6'h11;
  localparam logic [FN_W-1:0] FN_MFLO  = 6'h12;
  localparam logic [FN_W-1:0] FN_MTLO  = 6'h13;
  localparam logic [FN_W-1:0] FN_MULT  = 6'h18;
  localparam logic [FN_W-1:0] FN_MULTU = 6'h19;
  localparam logic [FN_W-1:0] FN_DIV   = 6'h1A;
  localparam logic [FN_W-1:0] FN_DIVU  = 6'h1B;
  localparam logic [FN_W-1:0] FN_ADD   = 6'h20;
  localparam logic [FN_W-1:0] FN_ADDU  = 6'h21;
  localparam logic [FN_W-1:0] FN_SUB   = 6'h22;
  localparam logic [FN_W-1:0] FN_SUBU  = 6'h23;
  localparam logic [FN_W-1:0] FN_AND   = 6'h24;
  localparam logic [FN_W-1:0] FN_OR    = 6'h25;
  localparam logic [FN_W-1:0] FN_XOR   = 6'h26;
  localparam logic [FN_W-1:0] FN_NOR   = 6'h27;
  localparam logic [FN_W-1:0] FN_SLT   = 6'h2A;
  localparam logic [FN_W-1:0] FN_SLTU  = 6'h2B;

  // REGIMM rt selectors
  localparam logic [RT_W-1:0] RT_BLTZ   = 5'h00;
  localparam logic [RT_W-1:0] RT_BGEZ   = 5'h01;
  localparam logic [RT_W-1:0] RT_BLTZAL = 5'h10;
  localparam logic [RT_W-1:0] RT_BGEZAL = 5'h11;

  // pc_src encodings
  localparam logic [SEL_W-1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [SEL_W-1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [SEL_W-1:0] PC_SRC_REG    = 2'd3;

  // reg_dst encodings
  localparam logic [SEL_W-1:0] REG_DST_RT = 2'd0;
  localparam logic [SEL_W-1:0] REG_DST_RD = 2'd1;
  localparam logic [SEL_W-1:0] REG_DST_RA = 2'd2;

  // mem_to_reg encodings
  localparam logic [SEL_W-1:0] M2R_ALU  = 2'd0;
  localparam logic [SEL_W-1:0] M2R_MEM  = 2'd1;
  localparam logic [SEL_W-1:0] M2R_LINK = 2'd2;

endpackage

// File: rtl/mips_instr_class.sv
// Combinational instruction classifier for the latched IR fields.
// Inputs : opcode, funct, rt (latched in DECODE)
// Outputs: one flag per execution class; an instruction with no flag set
//          is unknown and retires as a NOP.
module mips_instr_class
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output logic       is_alu,
  output logic       uses_rd,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_link,
  output logic       is_jump,
  output logic       is_jr,
  output logic       is_jalr,
  output logic       is_mthi,
  output logic       is_mtlo,
  output logic       is_muldiv,
  output logic       is_mul
);

  always_comb begin
    is_alu    = 1'b0;
    uses_rd   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_link   = 1'b0;
    is_jump   = 1'b0;
    is_jr     = 1'b0;
    is_jalr   = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    is_muldiv = 1'b0;
    is_mul    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_MFHI, FN_MFLO,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            is_alu  = 1'b1;
            uses_rd = 1'b1;
          end
          FN_JR:   is_jr = 1'b1;
          FN_JALR: begin
            is_jalr = 1'b1;
            uses_rd = 1'b1;
          end
          FN_MTHI: is_mthi = 1'b1;
          FN_MTLO: is_mtlo = 1'b1;
          FN_MULT, FN_MULTU: begin
            is_muldiv = 1'b1;
            is_mul    = 1'b1;
          end
          FN_DIV, FN_DIVU: is_muldiv = 1'b1;
          default: ;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: is_branch = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            is_branch = 1'b1;
            is_link   = 1'b1;
          end
          default: ;
        endcase
      end
      OP_J:   is_jump = 1'b1;
      OP_JAL: begin
        is_jump = 1'b1;
        is_link = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_branch = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: is_alu = 1'b1;
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: is_load = 1'b1;
      OP_SB, OP_SH, OP_SW: is_store = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, stretches bus states on mem_waitrequest,
// stalls for the fixed-latency mul/div unit and halts on JR to address 0.
// Inputs : clk, reset (async, active-high), IR fields opcode/funct/rt,
//          branch_cond, jr_target_zero, mem_waitrequest.
// Outputs: active plus datapath strobes and mux selects; all decoded
//          from state and the IR fields latched in DECODE so they are
//          valid in the cycle the state is entered.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned DIV_LATENCY = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       branch_cond,
  input  logic       jr_target_zero,
  input  logic       mem_waitrequest,
  output logic       active,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       mem_addr_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       hi_write,
  output logic       lo_write,
  output logic       muldiv_start
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [FN_W-1:0]   funct_q, funct_d;
  logic [RT_W-1:0]   rt_q, rt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic is_alu, uses_rd, is_load, is_store, is_branch, is_link, is_jump;
  logic is_jr, is_jalr, is_mthi, is_mtlo, is_muldiv, is_mul;

  // Classification of the instruction latched in DECODE
  mips_instr_class u_class (
    .opcode    (opcode_q),
    .funct     (funct_q),
    .rt        (rt_q),
    .is_alu    (is_alu),
    .uses_rd   (uses_rd),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_link   (is_link),
    .is_jump   (is_jump),
    .is_jr     (is_jr),
    .is_jalr   (is_jalr),
    .is_mthi   (is_mthi),
    .is_mtlo   (is_mtlo),
    .is_muldiv (is_muldiv),
    .is_mul    (is_mul)
  );

  // State, latched IR fields and mul/div stall counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      opcode_q <= '0;
      funct_q  <= '0;
      rt_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
      rt_q     <= rt_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    funct_d      = funct_q;
    rt_d         = rt_q;
    cnt_d        = cnt_q;
    active       = (state_q != ST_HALTED);
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_SEQ;
    mem_addr_sel = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = REG_DST_RT;
    mem_to_reg   = M2R_ALU;
    hi_write     = 1'b0;
    lo_write     = 1'b0;
    muldiv_start = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (!mem_waitrequest) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        opcode_d = opcode;
        funct_d  = funct;
        rt_d     = rt;
        state_d  = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        if (is_alu) begin
          state_d = ST_WB;
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
        end else if (is_branch || is_jump) begin
          pc_write = 1'b1;
          if (is_jump)          pc_src = PC_SRC_JUMP;
          else if (branch_cond) pc_src = PC_SRC_BRANCH;
          // Link is written whether or not the branch is taken
          if (is_link) begin
            reg_write  = 1'b1;
            reg_dst    = REG_DST_RA;
            mem_to_reg = M2R_LINK;
          end
        end else if (is_jr) begin
          // JR to address 0 is the halt convention; it never retires
          if (jr_target_zero) begin
            state_d = ST_HALTED;
          end else begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_REG;
          end
        end else if (is_jalr) begin
          pc_write   = 1'b1;
          pc_src     = PC_SRC_REG;
          reg_write  = 1'b1;
          reg_dst    = REG_DST_RD;
          mem_to_reg = M2R_LINK;
        end else if (is_mthi || is_mtlo) begin
          hi_write = is_mthi;
          lo_write = is_mtlo;
          pc_write = 1'b1;
        end else if (is_muldiv) begin
          muldiv_start = 1'b1;
          cnt_d        = is_mul ? CNT_W'(MUL_LATENCY) : CNT_W'(DIV_LATENCY);
          state_d      = ST_MULDIV_WAIT;
        end else begin
          pc_write = 1'b1;
        end
      end

      ST_MEM: begin
        mem_addr_sel = 1'b1;
        mem_read     = is_load;
        mem_write    = is_store;
        if (!mem_waitrequest) begin
          if (is_load) begin
            state_d = ST_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        reg_dst    = uses_rd ? REG_DST_RD : REG_DST_RT;
        mem_to_reg = is_load ? M2R_MEM : M2R_ALU;
        state_d    = ST_FETCH;
      end

      ST_MULDIV_WAIT: begin
        // Counter was loaded with the latency, so this state lasts exactly that long
        if (cnt_q <= CNT_W'(1)) begin
          hi_write = 1'b1;
          lo_write = 1'b1;
          pc_write = 1'b1;
          cnt_d    = '0;
          state_d  = ST_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_HALTED: ;

      default: state_d = ST_FETCH;
    endcase

    // Strobes are forced low for the whole time reset is held
    if (reset) begin
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PC_SRC_SEQ;
      mem_addr_sel = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      reg_dst      = REG_DST_RT;
      mem_to_reg   = M2R_ALU;
      hi_write     = 1'b0;
      lo_write     = 1'b0;
      muldiv_start = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control. Each instruction is
// expanded by a reference model into its expected per-cycle output trace,
// which is then replayed against the DUT one cycle at a time. IR fields
// carry the real instruction only in the DECODE cycle and random values
// elsewhere, so the EXEC/MEM/WB checks also cover the DECODE latch.
module tb_mips_multicycle_control;

  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 32;

  localparam int K_NOP   = 0;
  localparam int K_ALU_R = 1;
  localparam int K_ALU_I = 2;
  localparam int K_LOAD  = 3;
  localparam int K_STORE = 4;
  localparam int K_BR    = 5;
  localparam int K_BRL   = 6;
  localparam int K_J     = 7;
  localparam int K_JAL   = 8;
  localparam int K_JR    = 9;
  localparam int K_JALR  = 10;
  localparam int K_MTHI  = 11;
  localparam int K_MTLO  = 12;
  localparam int K_MUL   = 13;
  localparam int K_DIV   = 14;

  typedef struct packed {
    logic       active;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_addr_sel;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       hi_write;
    logic       lo_write;
    logic       muldiv_start;
  } outs_t;

  typedef struct packed {
    logic  wr;
    logic  dec;
    outs_t o;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic [4:0] rt = '0;
  logic       branch_cond = 1'b0;
  logic       jr_target_zero = 1'b0;
  logic       mem_waitrequest = 1'b0;
  logic       active, ir_write, pc_write, mem_addr_sel, mem_read, mem_write;
  logic       reg_write, hi_write, lo_write, muldiv_start;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  outs_t      got;

  cyc_t       exp_q[$];
  logic [5:0] cur_op, cur_fn;
  logic [4:0] cur_rt;
  logic       cur_bc, cur_jz;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  mips_multicycle_control #(
    .MUL_LATENCY (MUL_LAT),
    .DIV_LATENCY (DIV_LAT),
    .CNT_W       (6)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .opcode          (opcode),
    .funct           (funct),
    .rt              (rt),
    .branch_cond     (branch_cond),
    .jr_target_zero  (jr_target_zero),
    .mem_waitrequest (mem_waitrequest),
    .active          (active),
    .ir_write        (ir_write),
    .pc_write        (pc_write),
    .pc_src          (pc_src),
    .mem_addr_sel    (mem_addr_sel),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .reg_write       (reg_write),
    .reg_dst         (reg_dst),
    .mem_to_reg      (mem_to_reg),
    .hi_write        (hi_write),
    .lo_write        (lo_write),
    .muldiv_start    (muldiv_start)
  );

  assign got = {active, ir_write, pc_write, pc_src, mem_addr_sel, mem_read,
                mem_write, reg_write, reg_dst, mem_to_reg, hi_write, lo_write,
                muldiv_start};

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp_v);
    end
  endtask

  function automatic outs_t idle();
    outs_t o;
    o = '0;
    o.active = 1'b1;
    return o;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic wr, input logic dec, input outs_t o);
    cyc_t c;
    c.wr  = wr;
    c.dec = dec;
    c.o   = o;
    exp_q.push_back(c);
  endtask

  // Instruction class straight from the ISA tables
  function automatic int classify(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
    if (op == 6'h00) begin
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                     [6'h20:6'h27], 6'h2A, 6'h2B}) return K_ALU_R;
      if (fn == 6'h08) return K_JR;
      if (fn == 6'h09) return K_JALR;
      if (fn == 6'h11) return K_MTHI;
      if (fn == 6'h13) return K_MTLO;
      if (fn inside {6'h18, 6'h19}) return K_MUL;
      if (fn inside {6'h1A, 6'h1B}) return K_DIV;
      return K_NOP;
    end
    if (op == 6'h01) begin
      if (r inside {5'h00, 5'h01}) return K_BR;
      if (r inside {5'h10, 5'h11}) return K_BRL;
      return K_NOP;
    end
    if (op == 6'h02) return K_J;
    if (op == 6'h03) return K_JAL;
    if (op inside {[6'h04:6'h07]}) return K_BR;
    if (op inside {[6'h08:6'h0F]}) return K_ALU_I;
    if (op inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26}) return K_LOAD;
    if (op inside {6'h28, 6'h29, 6'h2B}) return K_STORE;
    return K_NOP;
  endfunction

  // Expands one instruction into its expected cycle-by-cycle trace
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r,
                             input logic bc, input logic jz, input int nf, input int nm);
    outs_t o;
    outs_t z;
    int    k;
    int    lat;
    z      = '0;
    cur_op = op;
    cur_fn = fn;
    cur_rt = r;
    cur_bc = bc;
    cur_jz = jz;
    k      = classify(op, fn, r);
    o = idle();
    o.mem_read = 1'b1;
    for (int i = 0; i < nf; i++) push(1'b1, 1'b0, o);
    o.ir_write = 1'b1;
    push(1'b0, 1'b0, o);
    push(rnd_bit(), 1'b1, idle());
    o = idle();
    case (k)
      K_ALU_R, K_ALU_I: begin
        push(rnd_bit(), 1'b0, o);
        o.reg_write = 1'b1;
        o.pc_write  = 1'b1;
        o.reg_dst   = (k == K_ALU_R) ? 2'd1 : 2'd0;
        push(rnd_bit(), 1'b0, o);
      end
      K_LOAD, K_STORE: begin
        push(rnd_bit(), 1'b0, o);
        o.mem_addr_sel = 1'b1;
        o.mem_read     = (k == K_LOAD);
        o.mem_write    = (k == K_STORE);
        for (int i = 0; i < nm; i++) push(1'b1, 1'b0, o);
        o.pc_write = (k == K_STORE);
        push(1'b0, 1'b0, o);
        if (k == K_LOAD) begin
          o = idle();
          o.reg_write  = 1'b1;
          o.pc_write   = 1'b1;
          o.mem_to_reg = 2'd1;
          push(rnd_bit(), 1'b0, o);
        end
      end
      K_BR, K_BRL, K_J, K_JAL: begin
        o.pc_write = 1'b1;
        o.pc_src   = (k == K_J || k == K_JAL) ? 2'd2 : (bc ? 2'd1 : 2'd0);
        if (k == K_BRL || k == K_JAL) begin
          o.reg_write  = 1'b1;
          o.reg_dst    = 2'd2;
          o.mem_to_reg = 2'd2;
        end
        push(rnd_bit(), 1'b0, o);
      end
      K_JR: begin
        if (jz) begin
          push(rnd_bit(), 1'b0, o);
          for (int i = 0; i < 20; i++) push(rnd_bit(), 1'b0, z);
        end else begin
          o.pc_write = 1'b1;
          o.pc_src   = 2'd3;
          push(rnd_bit(), 1'b0, o);
        end
      end
      K_JALR: begin
        o.pc_write   = 1'b1;
        o.pc_src     = 2'd3;
        o.reg_write  = 1'b1;
        o.reg_dst    = 2'd1;
        o.mem_to_reg = 2'd2;
        push(rnd_bit(), 1'b0, o);
      end
      K_MTHI, K_MTLO: begin
        o.pc_write = 1'b1;
        o.hi_write = (k == K_MTHI);
        o.lo_write = (k == K_MTLO);
        push(rnd_bit(), 1'b0, o);
      end
      K_MUL, K_DIV: begin
        lat = (k == K_MUL) ? int'(MUL_LAT) : int'(DIV_LAT);
        o.muldiv_start = 1'b1;
        push(rnd_bit(), 1'b0, o);
        o = idle();
        for (int i = 1; i < lat; i++) push(rnd_bit(), 1'b0, o);
        o.hi_write = 1'b1;
        o.lo_write = 1'b1;
        o.pc_write = 1'b1;
        push(rnd_bit(), 1'b0, o);
      end
      default: begin
        o.pc_write = 1'b1;
        push(rnd_bit(), 1'b0, o);
      end
    endcase
  endtask

  // Replays up to n expected cycles; also releases reset on the first one
  task automatic run_q(input string name, input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      c = exp_q.pop_front();
      @(negedge clk);
      reset           = 1'b0;
      mem_waitrequest = c.wr;
      branch_cond     = cur_bc;
      jr_target_zero  = cur_jz;
      if (c.dec) begin
        opcode = cur_op;
        funct  = cur_fn;
        rt     = cur_rt;
      end else begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        rt     = 5'($urandom);
      end
      #1;
      check_eq($sformatf("%s cyc%0d", name, i + 1), got, c.o);
    end
  endtask

  task automatic do_reset(input string name);
    exp_q.delete();
    @(negedge clk);
    reset           = 1'b1;
    mem_waitrequest = 1'b0;
    #1;
    check_eq({name, " rst_assert"}, got, idle());
    @(negedge clk);
    #1;
    check_eq({name, " rst_hold"}, got, idle());
  endtask

  initial begin
    do_reset("init");

    // ADDU, no waits
    model_instr(6'h00, 6'h21, 5'h00, 1'b0, 1'b0, 0, 0);
    run_q("addu", 1000);
    // LW with 3 MEM wait cycles
    model_instr(6'h23, 6'h00, 5'h00, 1'b0, 1'b0, 0, 3);
    run_q("lw_wait", 1000);
    // MULT then DIV
    model_instr(6'h00, 6'h18, 5'h00, 1'b0, 1'b0, 0, 0);
    run_q("mult", 1000);
    model_instr(6'h00, 6'h1A, 5'h00, 1'b0, 1'b0, 0, 0);
    run_q("div", 1000);
    // BEQ taken, BLTZAL not taken
    model_instr(6'h04, 6'h00, 5'h00, 1'b1, 1'b0, 0, 0);
    run_q("beq", 1000);
    model_instr(6'h01, 6'h00, 5'h10, 1'b0, 1'b0, 0, 0);
    run_q("bltzal", 1000);
    // JALR never halts even with a zero target
    model_instr(6'h00, 6'h09, 5'h00, 1'b0, 1'b1, 1, 0);
    run_q("jalr_z", 1000);

    // Reset mid-MULDIV_WAIT, then normal instruction
    model_instr(6'h00, 6'h1B, 5'h00, 1'b0, 1'b0, 0, 0);
    run_q("divu_cut", 8);
    do_reset("divu_cut");
    model_instr(6'h00, 6'h21, 5'h00, 1'b0, 1'b0, 0, 0);
    run_q("addu_after_div", 1000);

    // Reset mid-MEM store held by waitrequest
    model_instr(6'h2B, 6'h00, 5'h00, 1'b0, 1'b0, 0, 5);
    run_q("sw_cut", 5);
    do_reset("sw_cut");
    model_instr(6'h2B, 6'h00, 5'h00, 1'b0, 1'b0, 1, 1);
    run_q("sw_after", 1000);

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] r;
      logic       jz;
      int         nf;
      int         nm;
      op = 6'($urandom);
      fn = 6'($urandom);
      r  = 5'($urandom);
      case ($urandom_range(0, 5))
        0, 1: op = 6'h00;
        2: begin
          op = 6'h01;
          if ($urandom_range(0, 3) != 0) r = {rnd_bit(), 3'b000, rnd_bit()};
        end
        default: ;
      endcase
      jz = rnd_bit();
      if (op == 6'h00 && fn == 6'h08) jz = 1'b0;
      nf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      nm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      model_instr(op, fn, r, rnd_bit(), jz, nf, nm);
      run_q($sformatf("rnd%0d op%h fn%h rt%h", n, op, fn, r), 1000);
    end

    // JR to zero halts for good; reset recovers
    model_instr(6'h00, 6'h08, 5'h00, 1'b0, 1'b1, 1, 0);
    run_q("jr_halt", 1000);
    do_reset("halt");
    model_instr(6'h00, 6'h21, 5'h00, 1'b0, 1'b0, 0, 0);
    run_q("addu_after_halt", 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Sequential, parametrised successor to the single-cycle control decoder for the multi-cycle MIPS core.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Stretches memory states on an Avalon-style waitrequest and stalls for a fixed-latency multiply/divide unit before committing HI/LO.
- Sits between the instruction register, the memory bus interface and the datapath muxes; detects the halt condition (JR to address 0).

Parameters:
- MUL_LATENCY, 4: cycles MULT/MULTU spend in MULDIV_WAIT (legal range 1..63).
- DIV_LATENCY, 32: cycles DIV/DIVU spend in MULDIV_WAIT (legal range 1..63).
- CNT_W, 6: stall counter width; must satisfy 2**CNT_W > max(MUL_LATENCY, DIV_LATENCY).

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces FETCH and all outputs to 0 (active=1)
- opcode  in  6  instr[31:26] from IR; sampled in DECODE
- funct  in  6  instr[5:0] from IR; sampled in DECODE
- rt  in  5  instr[20:16] from IR; sampled in DECODE (REGIMM select)
- branch_cond  in  1  datapath comparator result for the latched branch, valid in EXEC
- jr_target_zero  in  1  rs value == 0, valid in EXEC
- mem_waitrequest  in  1  bus stall; holds FETCH/MEM while 1
- active  out  1  1 unless state==HALTED
- ir_write  out  1  latch read data into IR
- pc_write  out  1  one pulse per retired instruction
- pc_src  out  2  0 PC+4, 1 branch target, 2 jump target, 3 register (JR/JALR)
- mem_addr_sel  out  1  0 PC, 1 ALU result
- mem_read  out  1
- mem_write  out  1
- reg_write  out  1
- reg_dst  out  2  0 rt, 1 rd, 2 $ra
- mem_to_reg  out  2  0 ALU, 1 memory, 2 PC+8 (link)
- hi_write  out  1
- lo_write  out  1
- muldiv_start  out  1  one-cycle start pulse to the mul/div unit

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, MULDIV_WAIT, HALTED. All outputs are decoded from state plus opcode/funct/rt latched in DECODE. Outputs are 0 unless listed for a state.
- FETCH: mem_read=1, mem_addr_sel=0. While waitrequest=1: stay, ir_write=0. Else: ir_write=1, go to DECODE.
- DECODE: latch opcode/funct/rt; go to EXEC.
- EXEC, by class:
  - R-type ALU or MFHI/MFLO: go to WB.
  - Immediate ALU: go to WB.
  - Load (0x23, 0x20, 0x24, 0x21, 0x25, 0x22, 0x26) or store (0x28, 0x29, 0x2B): go to MEM.
  - Branches (0x04–0x07, REGIMM rt 0/1): pc_write=1, pc_src = branch_cond ? 1 : 0; go to FETCH.
  - REGIMM rt 0x10/0x11 (BLTZAL/BGEZAL): additionally reg_write=1, reg_dst=2, mem_to_reg=2, unconditionally.
  - J: pc_write=1, pc_src=2; go to FETCH.
  - JAL: as J plus reg_write=1, reg_dst=2, mem_to_reg=2.
  - JR: if jr_target_zero, go to HALTED with no pc_write. Else pc_write=1, pc_src=3; go to FETCH.
  - JALR: pc_write=1, pc_src=3, reg_write=1, reg_dst=1, mem_to_reg=2; go to FETCH. JALR never halts.
  - MTHI / MTLO: hi_write / lo_write=1, pc_write=1, pc_src=0; go to FETCH.
  - MULT/MULTU/DIV/DIVU: muldiv_start=1, counter <= MUL_LATENCY or DIV_LATENCY; go to MULDIV_WAIT.
  - Unknown opcode: treated as NOP (pc_write=1, pc_src=0); go to FETCH.
- MEM: mem_addr_sel=1; mem_read (loads) or mem_write (stores) held while waitrequest=1. On waitrequest=0: loads go to WB; stores pulse pc_write=1, pc_src=0 and go to FETCH.
- WB: reg_write=1, pc_write=1, pc_src=0. reg_dst=1 for R-type, 0 otherwise. mem_to_reg=1 for loads, 0 otherwise. Go to FETCH.
- MULDIV_WAIT: counter decrements each cycle. When counter==1: hi_write=lo_write=1, pc_write=1, pc_src=0; go to FETCH. Total stall equals the latency parameter exactly.
- HALTED: absorbing state; all outputs 0, active=0. Exits only on reset.
- Latency with no waitrequest:
  - ALU: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch/jump: 3 cycles
  - mult/div: 3 + latency cycles
- Reset asserted in any state, including mid-MEM or mid-MULDIV_WAIT: state goes to FETCH immediately, counter cleared, no write strobes. Strobe outputs must be glitch-free on reset assertion.
- waitrequest is ignored outside FETCH and MEM.

Decomposition:
- mips_pkg: state enum, opcode/funct/REGIMM-rt constants, pc_src/reg_dst/mem_to_reg encodings.
- One sub-module, mips_instr_class: combinational classifier (latched opcode/funct/rt → is_load, is_store, is_branch, is_link, is_muldiv, is_mul, uses_rd). Replaces the old inline decode.

Test Plan:
- ADDU, waitrequest=0 → ir_write at cycle 1; reg_write=1, reg_dst=1, pc_write=1 at cycle 4 only.
- LW, waitrequest held 3 cycles in MEM → mem_read/mem_addr_sel=1 for 4 cycles; WB with mem_to_reg=1; total 8 cycles.
- MULT with MUL_LATENCY=4, then DIV with DIV_LATENCY=32 → hi_write=lo_write single pulse at cycle 7 and 35 after the respective FETCH; muldiv_start single pulse.
- BEQ, branch_cond=1 → pc_src=1. BLTZAL (rt=0x10), branch_cond=0 → pc_src=0, reg_write=1, reg_dst=2, mem_to_reg=2.
- JR, jr_target_zero=1 → HALTED, active=0, no further strobes for 20 cycles. Then reset → active=1 and FETCH.
- Reset pulse mid-MULDIV_WAIT and mid-MEM store → no hi_write/mem_write after reset edge; FETCH resumes next cycle.
